// File: rtl/barrett_param_gen_if.sv
// rtl/barrett_param_gen_if.sv - start/done handshake bundle for the Barrett constant generator
interface barrett_param_gen_if #(
  parameter int QW  = 64,
  parameter int MUW = 31,
  parameter int KW  = 8
);
  logic           start;
  logic [QW-1:0]  q;
  logic           busy;
  logic           done;
  logic [MUW-1:0] mu;
  logic [KW-1:0]  k;
  logic           err;

  modport master (output start, q, input busy, done, mu, k, err);
  modport slave  (input start, q, output busy, done, mu, k, err);
endinterface

// File: rtl/barrett_param_gen.sv
// rtl/barrett_param_gen.sv - iterative k / mu = floor(2^(2k)/q) generator for the Barrett reducer
module barrett_param_gen #(
  parameter int QW  = 64,
  parameter int MUW = 31,
  parameter int KW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  barrett_param_gen_if.slave bus
);
  localparam int RW   = 31;
  localparam int QLIM = 29;
  localparam int IW   = KW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t         state;
  logic [QW-1:0]  q_r;
  logic [RW-1:0]  r;
  logic [MUW-1:0] quo;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  two_k;
  logic [KW-1:0]  k_r;
  logic           busy_r;
  logic           done_r;
  logic [MUW-1:0] mu_r;
  logic [KW-1:0]  k_out;
  logic           err_r;

  function automatic logic [KW-1:0] bit_len(input logic [QW-1:0] v);
    logic [KW-1:0] n;
    n = '0;
    for (int b = 0; b < QW; b++)
      if (v[b]) n = KW'(b + 1);
    return n;
  endfunction

  logic [KW-1:0]  k_enc;
  logic           range_err;
  logic           lead;
  logic [RW-1:0]  q_lo;
  logic [RW-1:0]  r_sh;
  logic           ge;
  logic [RW-1:0]  r_nx;
  logic [MUW-1:0] quo_nx;

  assign k_enc     = bit_len(q_r);
  assign range_err = (q_r == '0) || ((q_r >> QLIM) != '0);
  // The dividend 2^(2k) contributes a single 1 bit, at the first iteration.
  assign lead      = (idx == two_k);
  assign q_lo      = q_r[RW-1:0];
  assign r_sh      = (r << 1) | RW'(lead);
  assign ge        = (r_sh >= q_lo);
  assign r_nx      = ge ? (r_sh - q_lo) : r_sh;
  assign quo_nx    = (quo << 1) | MUW'(ge);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_r    <= '0;
      r      <= '0;
      quo    <= '0;
      idx    <= '0;
      two_k  <= '0;
      k_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      mu_r   <= '0;
      k_out  <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            q_r    <= bus.q;
            mu_r   <= '0;
            k_out  <= '0;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (range_err) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            k_r   <= k_enc;
            two_k <= {k_enc, 1'b0};
            idx   <= {k_enc, 1'b0};
            r     <= '0;
            quo   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          r   <= r_nx;
          quo <= quo_nx;
          if (idx == '0) begin
            mu_r   <= quo_nx;
            k_out  <= k_r;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.mu   = mu_r;
  assign bus.k    = k_out;
  assign bus.err  = err_r;
endmodule

// File: doc/barrett_param_gen.md
# barrett_param_gen

Iterative precompute stage that feeds `karatsuba_barrett`. It takes a modulus `q` and produces the Barrett constants that the reducer consumes: `k` (the bit length of `q`) and `mu = floor(2^(2k) / q)`. It uses a shift-subtract restoring divider, so only one modulus is in flight at a time, and results are handed over with a start/done handshake.

## Interface
Parameters:
- `QW`, 64, modulus width; matches `q` on the reducer.
- `MUW`, 31, width of `mu`; matches `mu` on the reducer.
- `KW`, 8, width of `k`; matches `k` on the reducer.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a computation. Sampled only in IDLE.
- `q` in QW: modulus. Captured on the accepted `start` edge.
- `busy` out 1: high from the cycle after accept until the cycle `done` pulses.
- `done` out 1: one-cycle pulse. `mu`, `k` and `err` are valid in that cycle.
- `mu` out MUW: `floor(2^(2k)/q)`. Held until the next accepted `start`.
- `k` out KW: bit length of `q`, i.e. `floor(log2 q) + 1`. Held.
- `err` out 1: `q` is out of range. Held.

## Operation
- Legal range is `1 <= q < 2^29`. That gives `k <= 29` and `mu <= 2^30`, so `mu` always fits in MUW.
- `q == 0` or `q >= 2^29` sets `err`. In that case `mu = 0` and `k = 0`.
- States:
  - IDLE: on `start=1`, register `q` into `q_r`, clear `mu`, `k` and `err`, go to LOAD.
  - LOAD: a priority encoder on `q_r` gives `k`.
    - Range error: set `err`, go to DONE.
    - Otherwise: remainder `r = 0`, quotient `quo = 0`, bit index `i = 2k`, go to DIV.
  - DIV: one restoring step per cycle over the dividend `2^(2k)`, whose bit `i` is 1 only when `i == 2k`.
    - `r' = (r << 1) | (i == 2k)`.
    - If `r' >= q_r`: `r = r' - q_r` and quotient bit 1. Otherwise `r = r'` and quotient bit 0.
    - `quo = (quo << 1) | bit`.
    - When `i == 0`, go to DONE. Otherwise decrement `i`.
    - Total of `2k+1` iterations.
  - DONE: drive `mu = quo[MUW-1:0]`, pulse `done`, go to IDLE.
- Widths:
  - `r` is 31 bits, since `r < q_r < 2^29` before the shift.
  - `quo` is MUW bits.
  - The compare and subtract are unsigned on 31 bits.
- `start` is ignored while not in IDLE. Changes to `q` while busy have no effect.
- If `start` is high in the same cycle `done` pulses, it is not accepted, because the FSM is in DONE. Acceptance happens on the next IDLE cycle.

## Timing
- Reset (`rst_n=0` at a rising edge) puts the FSM in IDLE and forces `busy=0`, `done=0`, `mu=0`, `k=0`, `err=0` from that edge. This applies in every state, including mid-DIV. Any partial result is discarded.
- Accept edge is E0. Counting from E0:
  - LOAD occupies E0 to E1.
  - DIV iterations complete at edges E2 through E(2k+2).
  - `done=1` at E(2k+3).
- Latency from accept to `done`:
  - Legal `q`: `2k+3` cycles.
  - `err` case: 2 cycles.
- `busy` is high from E0 through the cycle `done` is high. It drops together with `done`.
- Earliest next accept: the edge after `done`. Throughput is `2k+4` cycles per modulus.
- `mu`, `k` and `err` are registered outputs. They are stable from `done` until the next accept edge, where they clear to 0.

## Test plan
- `q=768112`, `start` for 1 cycle -> `k=20`, `mu=1431447`, `err=0`, `done` 43 cycles after accept, `busy` high for 43 cycles. Then feed `karatsuba_barrett` with `a=146712`, `b=248912` and compare `t` against `(a*b) mod q`.
- Small moduli:
  - `q=1` -> `k=1`, `mu=4`, latency 5.
  - `q=3` -> `k=2`, `mu=5`, latency 7.
- Upper bound, `q=536870911` (`2^29-1`) -> `k=29`, `mu=536870913`, latency 61, no truncation.
- Errors:
  - `q=0` -> `err=1`, `mu=0`, `k=0`, `done` 2 cycles after accept.
  - `q=536870912` (`2^29`) -> same error response.
  - `q=2^40` -> same error response.
- Control and reset:
  - Re-pulse `start` with `q=7` during DIV of `q=768112` -> ignored, result still `mu=1431447`.
  - Drive `rst_n=0` for one edge mid-DIV -> all outputs 0 at that edge.
  - Then `start` with `q=3` -> `mu=5`, `k=2`.
- Back-to-back:
  - `start` held high continuously with `q=768112` -> accepts every 44 cycles, each `done` shows `mu=1431447`.
